// File: rtl/rf_pkg.sv
// Shared constants, FSM state type and width helper for the banked operand register file.
package rf_pkg;

  localparam int unsigned RF_NUM_BANKS = 3;
  localparam int unsigned RF_DEPTH     = 5;
  localparam int unsigned RF_WIDTH     = 4;

  typedef enum logic {ST_IDLE, ST_STREAM} rf_state_e;

  // Ceiling log2, never below 1 so single-entry indices still get a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return (width == 0) ? 32'd1 : width;
  endfunction

endpackage

// File: rtl/rf_bank_ctl.sv
// Per-bank fill tracking: fill count doubles as write pointer; full when count hits DEPTH.
module rf_bank_ctl
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_rel,
  output logic [ADDR_W-1:0] o_wptr,
  output logic              o_full
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_rel) begin
      r_cnt <= '0;
    end else if (i_wr && !o_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_full = (r_cnt == CNT_W'(DEPTH));
  assign o_wptr = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/rf_banked_fill.sv
// Multi-bank operand register file: auto-filling write side, random reads, and a
// stream mode that drains a full bank in address order and then releases it.
module rf_banked_fill
  import rf_pkg::*;
#(
  parameter int unsigned NUM_BANKS = RF_NUM_BANKS,
  parameter int unsigned DEPTH     = RF_DEPTH,
  parameter int unsigned WIDTH     = RF_WIDTH,
  parameter int unsigned BANK_W    = clog2(NUM_BANKS),
  parameter int unsigned ADDR_W    = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_en,
  input  logic [BANK_W-1:0]    w_bank,
  input  logic [WIDTH-1:0]     w_data,
  output logic                 w_err,
  input  logic                 rel_en,
  input  logic [BANK_W-1:0]    rel_bank,
  input  logic                 r_en,
  input  logic [BANK_W-1:0]    r_bank,
  input  logic [ADDR_W-1:0]    r_addr,
  input  logic                 s_start,
  input  logic [BANK_W-1:0]    s_bank,
  output logic                 s_busy,
  output logic [WIDTH-1:0]     r_data,
  output logic                 r_valid,
  output logic                 r_last,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 all_full
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  rf_state_e         r_state, w_state_nxt;
  logic [BANK_W-1:0] r_sbank;
  logic [CNT_W-1:0]  r_sptr;
  logic [WIDTH-1:0]  r_mem [NUM_BANKS][DEPTH];

  logic [NUM_BANKS-1:0] w_wsel, w_relsel, w_ssel, w_sbsel, w_wr_stb, w_rel_stb;
  logic [ADDR_W-1:0]    w_wptr [NUM_BANKS];
  logic                 w_streaming, w_s_acc, w_s_done, w_wr_ok;
  logic [WIDTH-1:0]     w_rd_word, w_s0_word, w_sn_word;

  assign w_streaming = (r_state == ST_STREAM);
  assign s_busy      = w_streaming;
  // r_sptr reaching DEPTH means every word has been presented; this cycle releases the bank.
  assign w_s_done    = w_streaming && (r_sptr == CNT_W'(DEPTH));
  assign w_s_acc     = !w_streaming && s_start && |(w_ssel & bank_full);
  assign w_wr_ok     = w_en && |(w_wsel & ~bank_full) && !(rel_en && (rel_bank == w_bank));
  assign all_full    = &bank_full;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_wsel[b]    = (w_bank == BANK_W'(b));
    assign w_relsel[b]  = (rel_bank == BANK_W'(b));
    assign w_ssel[b]    = (s_bank == BANK_W'(b));
    assign w_sbsel[b]   = (r_sbank == BANK_W'(b));
    assign w_wr_stb[b]  = w_wr_ok && w_wsel[b];
    assign w_rel_stb[b] = (rel_en && w_relsel[b] && !(w_streaming && w_sbsel[b])
                           && !(w_s_acc && w_ssel[b])) || (w_s_done && w_sbsel[b]);

    rf_bank_ctl #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank_ctl (
      .clk   (clk),
      .rst_n (rst_n),
      .i_wr  (w_wr_stb[b]),
      .i_rel (w_rel_stb[b]),
      .o_wptr(w_wptr[b]),
      .o_full(bank_full[b])
    );
  end

  // Out-of-range bank/address never matches, so the muxes fall back to zero.
  always_comb begin
    w_rd_word = '0;
    w_s0_word = '0;
    w_sn_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (r_bank == BANK_W'(b) && r_addr == ADDR_W'(a)) w_rd_word = r_mem[b][a];
        if (s_bank == BANK_W'(b) && a == 0) w_s0_word = r_mem[b][a];
        if (r_sbank == BANK_W'(b) && r_sptr == CNT_W'(a)) w_sn_word = r_mem[b][a];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_s_acc)  w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_s_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Word 0 leaves on the accept edge, so the pointer starts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbank <= '0;
      r_sptr  <= '0;
    end else if (w_s_acc) begin
      r_sbank <= s_bank;
      r_sptr  <= CNT_W'(1);
    end else if (w_streaming && !w_s_done) begin
      r_sptr <= r_sptr + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int a = 0; a < DEPTH; a++) r_mem[b][a] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int a = 0; a < DEPTH; a++) begin
          if (w_wr_stb[b] && w_wptr[b] == ADDR_W'(a)) r_mem[b][a] <= w_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_err   <= w_en && !w_wr_ok;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      if (w_s_acc) begin
        r_data  <= w_s0_word;
        r_valid <= 1'b1;
      end else if (w_streaming) begin
        if (!w_s_done) begin
          r_data  <= w_sn_word;
          r_valid <= 1'b1;
          r_last  <= (r_sptr == CNT_W'(DEPTH - 1));
        end
      end else if (r_en) begin
        r_data  <= w_rd_word;
        r_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rf_banked_fill.md
Name: rf_banked_fill

Overview:
- Parametrised multi-bank register file for staging operand groups ahead of the MAC array.
- Write side: per-bank auto-incrementing pointer and fill tracking, with per-bank full flags.
- Read side: random-access reads, plus a streaming mode that drains a full bank in address order and then releases it automatically.
- One clock domain. Generalises the fixed 3-bank x 4-row x 4-bit file.

Parameters:
- NUM_BANKS, 3, number of banks (>=2)
- DEPTH, 5, words per bank (>=2)
- WIDTH, 4, bits per word
- BANK_W, max(1,clog2(NUM_BANKS)), derived bank index width
- ADDR_W, max(1,clog2(DEPTH)), derived address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- w_en  in  1  write request
- w_bank  in  BANK_W  target bank of write
- w_data  in  WIDTH  write data
- w_err  out  1  registered pulse: write dropped
- rel_en  in  1  release request (empties bank)
- rel_bank  in  BANK_W  bank to release
- r_en  in  1  random read request
- r_bank  in  BANK_W  read bank
- r_addr  in  ADDR_W  read address
- s_start  in  1  stream-drain request
- s_bank  in  BANK_W  bank to stream
- s_busy  out  1  stream in progress
- r_data  out  WIDTH  read/stream data
- r_valid  out  1  r_data valid
- r_last  out  1  final word of a stream
- bank_full  out  NUM_BANKS  per-bank full flag
- all_full  out  1  AND of bank_full

Behaviour:
- Reset: all storage, write pointers, fill counts and outputs are 0; FSM is in IDLE.
- Write (w_en): data goes to the bank's wptr, and wptr increments.
  - When the count reaches DEPTH, bank_full[b] is 1 from the next cycle.
  - The write is dropped, with w_err=1 on the next cycle, if the bank is full, w_bank>=NUM_BANKS, or the same bank is being released this cycle.
- Release (rel_en, valid non-streaming bank): wptr and full flag clear next cycle. Storage is not cleared.
  - Ignored if rel_bank>=NUM_BANKS or the bank is currently streaming.
- Random read: r_en at cycle N gives r_data/r_valid at N+1, r_last=0.
  - Same-cycle write to the same location returns the old data (read-before-write).
  - r_addr>=DEPTH or r_bank>=NUM_BANKS gives r_data=0 with r_valid=1.
  - r_en is ignored while s_busy.
- FSM IDLE to STREAM: on s_start when s_bank is valid and bank_full[s_bank]=1; otherwise s_start is ignored.
  - Accept at cycle N: s_busy=1 from N+1.
  - Words 0..DEPTH-1 appear at N+1..N+DEPTH with r_valid=1; r_last=1 at N+DEPTH only.
- FSM STREAM to IDLE: after the last word. The bank is auto-released, so bank_full=0 and s_busy=0 at N+DEPTH+1.
  - s_start during STREAM is ignored.
  - Writes to the streaming bank drop (it is full); writes to other banks proceed normally.
- Simultaneous r_en and s_start accepted in IDLE: stream wins and r_en is dropped.
- Reset mid-stream: FSM returns to IDLE, all banks empty, r_valid=0 immediately (asynchronous).
- Pointers wrap only via release, never modulo DEPTH.

Decomposition:
- Shared package (rf_pkg):
  - clog2 function
  - FSM state enum (ST_IDLE, ST_STREAM)
  - default NUM_BANKS/DEPTH/WIDTH constants shared with the MAC array
- Sub-module rf_bank_ctl, instantiated NUM_BANKS times: holds wptr, count and full flag; inputs are write strobe and release strobe; outputs are wptr and full.
- Top level holds storage, read mux, stream FSM and error logic.

Test Plan:
- Reset defaults: after reset, write 5 words 0x1..0x5 to bank 0 -> bank_full=3'b001 the cycle after the 5th write; r_en bank0 addr3 -> r_data=0x4 one cycle later.
- Overflow: a 6th write to bank 0 with data 0xF -> w_err pulses once; bank0 addr0 still reads 0x1.
- Stream: fill bank 1 with 0xA..0xE, s_start bank1 at N -> r_data 0xA..0xE at N+1..N+5, r_last only at N+5, bank_full[1]=0 and s_busy=0 at N+6.
- Stream gating: s_start on a non-full bank 2 -> s_busy stays 0; r_en during an active stream -> no extra r_valid.
- Simultaneous events: release and write to bank 2 in the same cycle -> w_err=1, bank 2 count is 0; fill all 3 banks -> all_full=1; w_bank=3 -> w_err=1.
- Mid-stream reset: assert rst_n low at N+2 of a stream -> r_valid, s_busy and bank_full are all 0 immediately.
